// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-seg scan controller: one digit per DIV-cycle slot, BLANK-cycle blank at each slot start.
// Outputs are registered one cycle after (cnt, idx, shadow); new data is taken only at frame boundaries via load_req/load_ack.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load_req,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_suppress,
  output logic [3:0]              digit_code,
  output logic                    seg_blank,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    load_ack,
  output logic                    frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;

  state_t                  state;
  logic                    last_cnt, last_idx, boundary, lit, zero_above, dp_cur;
  logic [NUM_DIGITS-1:0]   supp, an_d;
  logic [3:0]              code_d;

  // The slot phase is a pure function of the in-slot counter.
  assign state = (cnt_q < CW'(BLANK)) ? ST_BLANK : ST_ON;

  always_comb begin
    last_cnt   = (cnt_q == CW'(DIV - 1));
    last_idx   = (idx_q == IW'(NUM_DIGITS - 1));
    boundary   = en && last_cnt && last_idx;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    if (en) begin
      if (last_cnt) begin
        cnt_d = '0;
        idx_d = last_idx ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Walk from the most significant digit down so zero_above covers digits i..N-1.
    code_d     = 4'h0;
    dp_cur     = 1'b0;
    supp       = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (shadow_q[4*i +: 4] == 4'h0);
      if (i > 0) supp[i] = lz_suppress && zero_above;
      if (idx_q == IW'(i)) begin
        code_d = shadow_q[4*i +: 4];
        dp_cur = shadow_dp_q[i];
      end
    end

    lit = en && (state == ST_ON) && !supp[idx_q];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = !(lit && (idx_q == IW'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      digit_code  <= 4'h0;
      seg_blank   <= 1'b1;
      an_n        <= '1;
      dp_n        <= 1'b1;
      load_ack    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      digit_code <= code_d;
      seg_blank  <= !lit;
      an_n       <= an_d;
      dp_n       <= !(lit && dp_cur);
      frame_done <= boundary;
      load_ack   <= boundary && load_req;
      if (boundary && load_req) begin
        shadow_q    <= data_in;
        shadow_dp_q <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a slot/frame position model predicts every registered output cycle by cycle.
module tb_seg7_scan_ctrl;

  localparam int TB_N     = 4;
  localparam int TB_DIV   = 8;
  localparam int TB_BLANK = 2;

  typedef struct packed {
    logic [3:0]      code;
    logic            blank;
    logic [TB_N-1:0] an;
    logic            dp;
    logic            ack;
    logic            fd;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b1;
  logic             load_req = 1'b0;
  logic [15:0]      data_in = 16'h0;
  logic [TB_N-1:0]  dp_in = '0;
  logic             lz_suppress = 1'b0;
  logic [3:0]       digit_code;
  logic             seg_blank;
  logic [TB_N-1:0]  an_n;
  logic             dp_n;
  logic             load_ack;
  logic             frame_done;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  // Reference model: absolute enabled-cycle position within a frame plus the displayed value.
  int              pos = 0;
  logic [15:0]     m_val = 16'h0;
  logic [TB_N-1:0] m_dp = '0;
  logic            m_ack = 1'b0;

  seg7_scan_ctrl #(.NUM_DIGITS(TB_N), .DIV(TB_DIV), .BLANK(TB_BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load_req(load_req), .data_in(data_in),
    .dp_in(dp_in), .lz_suppress(lz_suppress), .digit_code(digit_code),
    .seg_blank(seg_blank), .an_n(an_n), .dp_n(dp_n), .load_ack(load_ack),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t dut_out();
    exp_t g;
    g.code  = digit_code;
    g.blank = seg_blank;
    g.an    = an_n;
    g.dp    = dp_n;
    g.ack   = load_ack;
    g.fd    = frame_done;
    return g;
  endfunction

  // Predict the outputs after the coming rising edge from the inputs now applied.
  task automatic model_step();
    int   cnt, idx;
    logic on, bnd;
    exp_t e;
    cnt = pos % TB_DIV;
    idx = (pos / TB_DIV) % TB_N;
    on  = en && (cnt >= TB_BLANK) && !(lz_suppress && idx > 0 && (m_val >> (4*idx)) == 16'h0);
    e.code  = m_val[4*idx +: 4];
    e.an    = '1;
    if (on) e.an[idx] = 1'b0;
    e.blank = !on;
    e.dp    = on ? !m_dp[idx] : 1'b1;
    bnd     = en && (cnt == TB_DIV - 1) && (idx == TB_N - 1);
    e.fd    = bnd;
    e.ack   = bnd && load_req;
    m_ack   = e.ack;
    if (e.ack) begin
      m_val = data_in;
      m_dp  = dp_in;
    end
    if (en) pos = (pos + 1) % (TB_N * TB_DIV);
    sb.push_back(e);
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  task automatic run_to(input int p);
    for (int n = 0; n < 2 * TB_N * TB_DIV && pos != p; n++) cyc();
  endtask

  task automatic load_value(input logic [15:0] v, input logic [TB_N-1:0] d);
    logic got;
    got      = 1'b0;
    data_in  = v;
    dp_in    = d;
    load_req = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      cyc();
      got = m_ack;
    end
    load_req = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL load_timeout: no boundary ack predicted for %h within 100 cycles", v);
    end
  endtask

  task automatic check_reset(input string name);
    exp_t g, r;
    r = '{code: 4'h0, blank: 1'b1, an: '1, dp: 1'b1, ack: 1'b0, fd: 1'b0};
    g = dut_out();
    vectors++;
    if (g !== r) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, g, r);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare one expected entry per edge.
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = dut_out();
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL out t=%0t: got code=%h blank=%b an=%b dp=%b ack=%b fd=%b, want code=%h blank=%b an=%b dp=%b ack=%b fd=%b",
                   $time, g.code, g.blank, g.an, g.dp, g.ack, g.fd,
                   e.code, e.blank, e.an, e.dp, e.ack, e.fd);
        end
      end
    end
  end

  initial begin
    #3 rst_n = 1'b0;
    #1 check_reset("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (64) cyc();

    run_to(10);
    load_value(16'h12A4, 4'b0100);
    repeat (40) cyc();

    run_to(10);
    data_in  = 16'hBEEF;
    dp_in    = 4'b1111;
    load_req = 1'b1;
    repeat (3) cyc();
    load_req = 1'b0;
    repeat (40) cyc();

    lz_suppress = 1'b1;
    load_value(16'h0030, 4'b0000);
    repeat (40) cyc();
    lz_suppress = 1'b0;
    repeat (40) cyc();
    lz_suppress = 1'b1;
    load_value(16'h0000, 4'b0001);
    repeat (40) cyc();
    lz_suppress = 1'b0;

    // Freeze at idx=1, cnt=5.
    run_to(13);
    en = 1'b0;
    repeat (10) cyc();
    en = 1'b1;
    repeat (40) cyc();

    for (int n = 0; n < 800; n++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) lz_suppress = ~lz_suppress;
      if (!load_req && $urandom_range(0, 19) == 0) begin
        data_in  = 16'($urandom);
        dp_in    = 4'($urandom);
        load_req = 1'b1;
      end else if (load_req && $urandom_range(0, 59) == 0) begin
        load_req = 1'b0;
      end
      cyc();
      if (m_ack && $urandom_range(0, 3) != 0) load_req = 1'b0;
    end

    en = 1'b1;
    lz_suppress = 1'b0;
    load_value(16'h9876, 4'b1010);
    run_to(4);
    data_in  = 16'h5555;
    load_req = 1'b1;
    cyc();
    #2 rst_n = 1'b0;
    sb.delete();
    pos   = 0;
    m_val = 16'h0;
    m_dp  = '0;
    #1 check_reset("reset_async");
    @(negedge clk);
    @(negedge clk);
    check_reset("reset_held");
    load_req = 1'b0;
    rst_n    = 1'b1;
    repeat (70) cyc();

    @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
